// File: rtl/lcd_win_proc.sv
// 2x2-window image processor: loads a W x H image from ROM, applies host window
// commands, and streams the buffer to RAM on request. Optional macro: LCD_AVG_ROUND_EN.
module lcd_win_proc #(
  parameter int DW     = 8,
  parameter int W_LOG2 = 3,
  parameter int H_LOG2 = 3,
  localparam int AW    = W_LOG2 + H_LOG2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          busy,
  output logic          rom_rd,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_q,
  output logic          ram_valid,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          done
);

  localparam int N = 1 << AW;
  localparam int W = 1 << W_LOG2;
  localparam int H = 1 << H_LOG2;

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_WDONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [H_LOG2-1:0]   r_q, r_d;
  logic [W_LOG2-1:0]   c_q, c_d;
  logic                busy_q, busy_d;
  logic                rom_rd_q, rom_rd_d;
  logic [AW-1:0]       rom_a_q, rom_a_d;
  logic                ram_valid_q, ram_valid_d;
  logic [AW-1:0]       ram_a_q, ram_a_d;
  logic [DW-1:0]       ram_d_q, ram_d_d;
  logic                done_q, done_d;

  logic [DW-1:0]       buf_q [N];
  logic                load_we;
  logic                win_we;

  logic [AW-1:0]       win_a [4];
  logic [DW-1:0]       win_v [4];
  logic [DW-1:0]       win_n [4];
  logic [DW-1:0]       win_max, win_min, win_avg;
  logic [DW+1:0]       win_sum, avg_sum;

  // Window element gi sits at row offset gi/2 and column offset gi%2 from the origin.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      logic [H_LOG2-1:0] row;
      logic [W_LOG2-1:0] col;
      assign row       = r_q + H_LOG2'(gi / 2);
      assign col       = c_q + W_LOG2'(gi % 2);
      assign win_a[gi] = {row, col};
      assign win_v[gi] = buf_q[win_a[gi]];
    end
  endgenerate

  always_comb begin
    win_max = win_v[0];
    win_min = win_v[0];
    win_sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (win_v[i] > win_max) win_max = win_v[i];
      if (win_v[i] < win_min) win_min = win_v[i];
      win_sum = win_sum + (DW+2)'(win_v[i]);
    end
`ifdef LCD_AVG_ROUND_EN
    avg_sum = win_sum + (DW+2)'(2);
`else
    avg_sum = win_sum;
`endif
    win_avg = avg_sum[DW+1:2];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) win_n[i] = win_v[i];
    win_we = (state_q == S_EXEC) && (cmd_q >= 4'd5) && (cmd_q <= 4'd11);
    case (cmd_q)
      4'd5:  for (int i = 0; i < 4; i++) win_n[i] = win_max;
      4'd6:  for (int i = 0; i < 4; i++) win_n[i] = win_min;
      4'd7:  for (int i = 0; i < 4; i++) win_n[i] = win_avg;
      4'd8:  begin
        win_n[0] = win_v[1]; win_n[1] = win_v[3];
        win_n[3] = win_v[2]; win_n[2] = win_v[0];
      end
      4'd9:  begin
        win_n[0] = win_v[2]; win_n[2] = win_v[3];
        win_n[3] = win_v[1]; win_n[1] = win_v[0];
      end
      4'd10: begin
        win_n[0] = win_v[2]; win_n[2] = win_v[0];
        win_n[1] = win_v[3]; win_n[3] = win_v[1];
      end
      4'd11: begin
        win_n[0] = win_v[1]; win_n[1] = win_v[0];
        win_n[2] = win_v[3]; win_n[3] = win_v[2];
      end
      default: ;
    endcase
  end

  // The buffer has no reset: a reset always re-enters LOAD, which rewrites every entry.
  always_ff @(posedge clk) begin
    if (load_we) begin
      buf_q[rom_a_q] <= rom_q;
    end else if (win_we) begin
      for (int i = 0; i < 4; i++) buf_q[win_a[i]] <= win_n[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    r_d         = r_q;
    c_d         = c_q;
    busy_d      = busy_q;
    rom_rd_d    = rom_rd_q;
    rom_a_d     = rom_a_q;
    ram_valid_d = ram_valid_q;
    ram_a_d     = ram_a_q;
    done_d      = done_q;
    load_we     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (!rom_rd_q) begin
          rom_rd_d = 1'b1;
        end else begin
          load_we = 1'b1;
          if (rom_a_q == {AW{1'b1}}) begin
            rom_rd_d = 1'b0;
            rom_a_d  = '0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            rom_a_d = rom_a_q + AW'(1);
          end
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d  = cmd;
          busy_d = 1'b1;
          if (cmd == 4'd0) begin
            state_d     = S_WRITE;
            ram_valid_d = 1'b1;
            ram_a_d     = '0;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        case (cmd_q)
          4'd1: if (r_q != '0) r_d = r_q - H_LOG2'(1);
          4'd2: if (r_q < H_LOG2'(H - 2)) r_d = r_q + H_LOG2'(1);
          4'd3: if (c_q != '0) c_d = c_q - W_LOG2'(1);
          4'd4: if (c_q < W_LOG2'(W - 2)) c_d = c_q + W_LOG2'(1);
          default: ;
        endcase
      end
      S_WRITE: begin
        if (ram_a_q == {AW{1'b1}}) begin
          ram_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_WDONE;
        end else begin
          ram_a_d = ram_a_q + AW'(1);
        end
      end
      S_WDONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_LOAD;
    endcase
    // RAM data is looked up from the next address so it leaves the register aligned with ram_a.
    ram_d_d = ram_valid_d ? buf_q[ram_a_d] : ram_d_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      cmd_q       <= '0;
      r_q         <= H_LOG2'(H / 2 - 1);
      c_q         <= W_LOG2'(W / 2 - 1);
      busy_q      <= 1'b1;
      rom_rd_q    <= 1'b0;
      rom_a_q     <= '0;
      ram_valid_q <= 1'b0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      r_q         <= r_d;
      c_q         <= c_d;
      busy_q      <= busy_d;
      rom_rd_q    <= rom_rd_d;
      rom_a_q     <= rom_a_d;
      ram_valid_q <= ram_valid_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign rom_rd    = rom_rd_q;
  assign rom_a     = rom_a_q;
  assign ram_valid = ram_valid_q;
  assign ram_a     = ram_a_q;
  assign ram_d     = ram_d_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lcd_win_proc.sv
// Bench for lcd_win_proc: directed command scripts from a table plus random
// command streams checked against a pixel-level reference model.
module tb_lcd_win_proc;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int N  = 64;
  localparam int W  = 8;
  localparam int H  = 8;
`ifdef LCD_AVG_ROUND_EN
  localparam int AVG_EXP = 32;
`else
  localparam int AVG_EXP = 31;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic          busy, rom_rd, ram_valid, done;
  logic [AW-1:0] rom_a, ram_a;
  logic [DW-1:0] rom_q, ram_d;

  lcd_win_proc dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .rom_rd(rom_rd), .rom_a(rom_a), .rom_q(rom_q), .ram_valid(ram_valid),
    .ram_a(ram_a), .ram_d(ram_d), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom_mem [N];
  logic [DW-1:0] ram_mem [N];
  assign rom_q = rom_mem[rom_a];
  always @(posedge clk) if (ram_valid === 1'b1) ram_mem[ram_a] <= ram_d;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: image contents and window origin.
  int model_img [N];
  int model_r, model_c;

  typedef struct { int scen; logic [3:0] op; int reps; } step_t;
  typedef struct { int scen; int addr; int val; } exp_t;

  step_t steps [14] = '{
    '{1, 4'd9, 1}, '{1, 4'd0, 1},
    '{2, 4'd7, 1}, '{2, 4'd0, 1},
    '{3, 4'd5, 1}, '{3, 4'd0, 1},
    '{4, 4'd1, 5}, '{4, 4'd3, 5}, '{4, 4'd6, 1}, '{4, 4'd0, 1},
    '{5, 4'd4, 7}, '{5, 4'd2, 7}, '{5, 4'd10, 1}, '{5, 4'd0, 1}
  };

  exp_t exps [23] = '{
    '{1, 27, 35}, '{1, 28, 27}, '{1, 35, 36}, '{1, 36, 28}, '{1, 0, 0}, '{1, 63, 63},
    '{2, 27, AVG_EXP}, '{2, 28, AVG_EXP}, '{2, 35, AVG_EXP}, '{2, 36, AVG_EXP},
    '{3, 27, 36}, '{3, 28, 36}, '{3, 35, 36}, '{3, 36, 36},
    '{4, 0, 0}, '{4, 1, 0}, '{4, 8, 0}, '{4, 9, 0}, '{4, 10, 10},
    '{5, 54, 62}, '{5, 62, 54}, '{5, 55, 63}, '{5, 63, 55}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_apply(input int c);
    int idx [4];
    int v [4];
    int s, mx, mn, nv;
    for (int i = 0; i < 4; i++) begin
      idx[i] = (model_r + i / 2) * W + model_c + i % 2;
      v[i]   = model_img[idx[i]];
    end
    s = v[0] + v[1] + v[2] + v[3];
    mx = v[0]; mn = v[0];
    for (int i = 1; i < 4; i++) begin
      if (v[i] > mx) mx = v[i];
      if (v[i] < mn) mn = v[i];
    end
`ifdef LCD_AVG_ROUND_EN
    nv = (s + 2) / 4;
`else
    nv = s / 4;
`endif
    case (c)
      1: if (model_r > 0) model_r--;
      2: if (model_r < H - 2) model_r++;
      3: if (model_c > 0) model_c--;
      4: if (model_c < W - 2) model_c++;
      5: for (int i = 0; i < 4; i++) model_img[idx[i]] = mx;
      6: for (int i = 0; i < 4; i++) model_img[idx[i]] = mn;
      7: for (int i = 0; i < 4; i++) model_img[idx[i]] = nv;
      8: begin
        model_img[idx[0]] = v[1]; model_img[idx[1]] = v[3];
        model_img[idx[3]] = v[2]; model_img[idx[2]] = v[0];
      end
      9: begin
        model_img[idx[0]] = v[2]; model_img[idx[2]] = v[3];
        model_img[idx[3]] = v[1]; model_img[idx[1]] = v[0];
      end
      10: begin
        model_img[idx[0]] = v[2]; model_img[idx[2]] = v[0];
        model_img[idx[1]] = v[3]; model_img[idx[3]] = v[1];
      end
      11: begin
        model_img[idx[0]] = v[1]; model_img[idx[1]] = v[0];
        model_img[idx[2]] = v[3]; model_img[idx[3]] = v[2];
      end
      default: ;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_rom_rd"}, rom_rd, 0);
    check({tag, "_rom_a"}, rom_a, 0);
    check({tag, "_ram_valid"}, ram_valid, 0);
    check({tag, "_ram_a"}, ram_a, 0);
    check({tag, "_ram_d"}, ram_d, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) model_img[k] = rom_mem[k];
    model_r = H / 2 - 1;
    model_c = W / 2 - 1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("load_rd", rom_rd, 1);
      check("load_a", rom_a, k);
      check("load_busy", busy, 1);
    end
    @(negedge clk);
    check("load_end_rd", rom_rd, 0);
    check("load_end_busy", busy, 0);
    $display("reset + load of %0d pixels complete", N);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("busy_timeout", busy, 0);
  endtask

  task automatic send_cmd(input logic [3:0] c);
    wait_idle();
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("accept_busy", busy, 1);
    // Hold a junk command while busy; it must be ignored.
    cmd = 4'($urandom_range(0, 15));
    if (c != 4'd0) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check("exec_busy_clear", busy, 0);
      model_apply(int'(c));
      $display("cmd %0d executed, origin (%0d,%0d)", c, model_r, model_c);
    end else begin
      for (int k = 0; k < N; k++) begin
        if (k > 0) @(negedge clk);
        if (k == 1) cmd_valid = 1'b0;
        check("wr_valid", ram_valid, 1);
        check("wr_addr", ram_a, k);
        check("wr_data", ram_d, model_img[k]);
        check("wr_busy", busy, 1);
      end
      @(negedge clk);
      check("wr_done", done, 1);
      check("wr_valid_end", ram_valid, 0);
      @(negedge clk);
      check("wr_done_once", done, 0);
      check("wr_busy_clear", busy, 0);
      $display("write round of %0d pixels complete", N);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) rom_mem[k] = DW'(k);
    for (int k = 0; k < N; k++) ram_mem[k] = '0;

    // Reset, full load, immediate write.
    do_reset();
    send_cmd(4'd0);

    // Directed scenarios, each from a fresh image.
    for (int s = 1; s <= 5; s++) begin
      do_reset();
      foreach (steps[i]) if (steps[i].scen == s)
        for (int r = 0; r < steps[i].reps; r++) send_cmd(steps[i].op);
      foreach (exps[i]) if (exps[i].scen == s)
        check($sformatf("scen%0d_ram%0d", s, exps[i].addr), ram_mem[exps[i].addr], exps[i].val);
    end

    // Reset in the middle of a write.
    wait_idle();
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midwr_active", ram_valid, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midwr");
    do_reset();
    send_cmd(4'd9);
    send_cmd(4'd0);
    check("midwr_origin_27", ram_mem[27], 35);
    check("midwr_origin_36", ram_mem[36], 28);
    send_cmd(4'd0);

    // Random image and command stream.
    for (int k = 0; k < N; k++) rom_mem[k] = DW'($urandom_range(0, 255));
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if (i % 16 == 15) send_cmd(4'd0);
      else send_cmd(4'($urandom_range(1, 15)));
    end
    send_cmd(4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_win_proc.md
# lcd_win_proc

Parametrised 2x2-window image processor for the LCD path. After reset it loads a W x H pixel image from the image ROM into an internal buffer. It then executes host commands (window shifts, max/min/average fill, rotations, mirrors) on a 2x2 window. On a write command it streams the whole buffer to the image RAM. Unlike the previous 8x8 controller, it returns to command mode after a write, so several process/write rounds can run without a reset.

## Interface
- DW, 8: pixel width in bits.
- W_LOG2, 3: log2 of image width W.
- H_LOG2, 3: log2 of image height H; both ≥1. AW = W_LOG2+H_LOG2, N = 2^AW.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cmd  in  4  command code.
- cmd_valid  in  1  command strobe; sampled only when busy=0.
- busy  out  1  block cannot accept a command.
- rom_rd  out  1  ROM read enable.
- rom_a  out  AW  ROM address.
- rom_q  in  DW  ROM data; combinational in rom_a, same cycle.
- ram_valid  out  1  RAM write strobe.
- ram_a  out  AW  RAM address.
- ram_d  out  DW  RAM data.
- done  out  1  one-cycle pulse after the last RAM write.

## Operation
- Pixel address = row*W + col.
- Window origin is (r,c): P0=(r,c), P1=(r,c+1), P2=(r+1,c), P3=(r+1,c+1).
- Origin reset value: (H/2-1, W/2-1), i.e. address 27 for 8x8.
- States: LOAD → IDLE ⇄ EXEC, IDLE → WRITE → IDLE. All outputs are registered.
- LOAD:
  - rom_rd=1, rom_a steps 0..N-1, one address per cycle.
  - buf[rom_a] <= rom_q on every cycle.
  - After address N-1 the block goes to IDLE.
- IDLE: busy=0. When cmd_valid=1, the block captures cmd. cmd=0 goes to WRITE; any other value goes to EXEC.
- EXEC: busy=1 for exactly one cycle, applies the captured command, then returns to IDLE.
- Command codes:
  - 1 up: r-=1 if r>0.
  - 2 down: r+=1 if r<H-2.
  - 3 left: c-=1 if c>0.
  - 4 right: c+=1 if c<W-2.
  - Blocked shifts leave the origin unchanged. The window never wraps or leaves the image.
  - 5: all four P positions <= max of the window.
  - 6: all four P positions <= min of the window.
  - 7: all four P positions <= average of the window (see Configuration).
  - 8 rotate CCW: P0<=P1, P1<=P3, P3<=P2, P2<=P0.
  - 9 rotate CW: P0<=P2, P2<=P3, P3<=P1, P1<=P0.
  - 10 mirror X: P0<->P2, P1<->P3.
  - 11 mirror Y: P0<->P1, P2<->P3.
  - 12-15: no-op; still spends one EXEC cycle.
- Arithmetic: the window sum is DW+2 bits wide and cannot overflow. Max/min compare unsigned.
- WRITE:
  - busy=1, ram_valid=1 for N consecutive cycles.
  - ram_a steps 0..N-1, with ram_d=buf[ram_a] in the same cycle.
  - The cycle after the last write: ram_valid=0, done=1 for one cycle, then IDLE.
  - The buffer and origin are preserved across the write.

## Timing
- Reset values: busy=1, rom_rd=0, rom_a=0, ram_valid=0, ram_a=0, ram_d=0, done=0. State=LOAD, origin at centre.
- LOAD timing: rom_rd rises on the first clk edge after reset deasserts and holds for exactly N cycles. busy falls on the edge after the last load cycle.
- Command latency: cmd is accepted in cycle t. busy=1 in cycle t+1. The result is visible in the buffer and busy=0 in cycle t+2.
- Write latency: accepted at t; ram_valid=1 in cycles t+1..t+N; done=1 in cycle t+N+1; busy=0 in cycle t+N+2.
- cmd_valid while busy=1 is ignored, not queued.
- Reset mid-operation (any state): immediate return to the reset values. LOAD restarts from address 0 and the buffer is fully reloaded.

## Configuration
- LCD_AVG_ROUND_EN defined: average = (sum+2)>>2, round-half-up.
- LCD_AVG_ROUND_EN undefined: average = sum>>2, truncation.
- Nothing else changes.

## Test plan
All scenarios use the default parameters with ROM[k]=k.
- Reset then wait: rom_rd high for 64 cycles with rom_a 0..63, then busy=0. An immediate cmd 0 gives ram_d=ram_a for all 64 writes, followed by one done pulse.
- cmd 9 at the centre, then cmd 0: RAM[27]=35, [28]=27, [35]=36, [36]=28; all other addresses unchanged.
- cmd 7 at the centre: all four pixels become 31 without the macro, 32 with LCD_AVG_ROUND_EN. cmd 5 on a fresh image: all four pixels become 36.
- Five cmd 1 then five cmd 3: origin clamps at (0,0). cmd 6 then sets RAM[0], [1], [8] and [9] to 0.
- Seven cmd 4 and seven cmd 2: origin clamps at (6,6). cmd 10 then gives RAM[54]=62, [62]=54, [55]=63, [63]=55.
- Assert reset in the middle of WRITE: outputs return to reset values within the same cycle. Rerun the full reload, confirm the window is back at 27, and check a second write round completes.
